comp1b_3op: RTL and testbench

Registered magnitude comparator producing three mutually exclusive flags (equal, greater, less) for two WIDTH-bit operands. The datapath is a cascade of 1-bit, 3-output comparator cells evaluated MSB-first, with the result captured into output registers on each clock edge. Sits in front of control logic that needs a clean, glitch-free, one-hot compare result per cycle.

---
 rtl/comp1b_3op_if.sv | 28 ++
 rtl/comp1b_3op.sv | 62 ++++++
 tb/tb_comp1b_3op.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/comp1b_3op_if.sv
// comp1b_3op_if: operand/result bundle for the registered 3-flag comparator.
//   en        capture enable (master -> comparator)
//   a, b      WIDTH-bit operands (master -> comparator)
//   c         registered a == b (comparator -> master)
//   agb       registered a >  b (comparator -> master)
//   alb       registered a <  b (comparator -> master)
//   out_valid flags hold the result of a real capture (comparator -> master)
interface comp1b_3op_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             agb;
  logic             alb;
  logic             out_valid;

  modport master (
    output en, a, b,
    input  c, agb, alb, out_valid
  );

  modport slave (
    input  en, a, b,
    output c, agb, alb, out_valid
  );
endinterface

// File: rtl/comp1b_3op.sv
// comp1b_3op: registered magnitude comparator built from a cascade of 1-bit,
// 3-output comparator cells evaluated MSB-first. The one-hot result
// (equal / greater / less) is captured into output registers when en=1.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all flags and out_valid
//   bus    comp1b_3op_if.slave: en, a, b in; c, agb, alb, out_valid out
// Parameters:
//   WIDTH  operand width (>= 1)
//   SIGNED 0 = unsigned compare, 1 = two's-complement compare
module comp1b_3op #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  comp1b_3op_if.slave bus
);

  logic eq_cmb;
  logic gt_cmb;
  logic lt_cmb;
  logic abit;
  logic bbit;

  // Cell chain from bit WIDTH-1 down to bit 0, seeded with eq=1, gt=0, lt=0.
  // For a signed compare the MSB cell sees its operand bits swapped, so a set
  // sign bit on a (negative) against a clear one on b reads as a < b.
  always_comb begin
    eq_cmb = 1'b1;
    gt_cmb = 1'b0;
    lt_cmb = 1'b0;
    abit   = 1'b0;
    bbit   = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if ((SIGNED != 0) && (k == 0)) begin
        abit = bus.b[WIDTH-1-k];
        bbit = bus.a[WIDTH-1-k];
      end else begin
        abit = bus.a[WIDTH-1-k];
        bbit = bus.b[WIDTH-1-k];
      end
      gt_cmb = gt_cmb | (eq_cmb & abit & ~bbit);
      lt_cmb = lt_cmb | (eq_cmb & ~abit & bbit);
      eq_cmb = eq_cmb & ~(abit ^ bbit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.c         <= 1'b0;
      bus.agb       <= 1'b0;
      bus.alb       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.en) begin
      bus.c         <= eq_cmb;
      bus.agb       <= gt_cmb;
      bus.alb       <= lt_cmb;
      bus.out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_comp1b_3op.sv
// tb_comp1b_3op: directed checks for comp1b_3op, one unsigned and one signed
// instance driven with the same operands. Flags are compared as the vector
// {out_valid, c, agb, alb}.
module tb_comp1b_3op;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_EQ   = 4'b1100;
  localparam logic [3:0] F_GT   = 4'b1010;
  localparam logic [3:0] F_LT   = 4'b1001;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  comp1b_3op_if #(.WIDTH(4)) ifu ();
  comp1b_3op_if #(.WIDTH(4)) ifs ();

  comp1b_3op #(.WIDTH(4), .SIGNED(0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifu)
  );

  comp1b_3op #(.WIDTH(4), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,c,gt,lt}=%b, expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_u();
    return {ifu.out_valid, ifu.c, ifu.agb, ifu.alb};
  endfunction

  function automatic logic [3:0] flags_s();
    return {ifs.out_valid, ifs.c, ifs.agb, ifs.alb};
  endfunction

  // Reference compare by integer value, independent of the bit cascade.
  function automatic logic [3:0] ref_flags(input logic [3:0] x, input logic [3:0] y, input bit sgn);
    int xv;
    int yv;
    xv = sgn ? int'($signed(x)) : int'(x);
    yv = sgn ? int'($signed(y)) : int'(y);
    if (xv == yv) return F_EQ;
    else if (xv > yv) return F_GT;
    else return F_LT;
  endfunction

  task automatic apply(input logic [3:0] x, input logic [3:0] y);
    ifu.a = x;
    ifu.b = y;
    ifs.a = x;
    ifs.b = y;
  endtask

  task automatic set_en(input logic e);
    ifu.en = e;
    ifs.en = e;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_u;
    logic [3:0] exp_s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    set_en(1'b1);
    apply(4'b0000, 4'b0000);

    vecs.push_back('{"0101/0011", 4'b0101, 4'b0011, F_GT, F_GT});
    vecs.push_back('{"0010/0110", 4'b0010, 4'b0110, F_LT, F_LT});
    vecs.push_back('{"1111/1111", 4'b1111, 4'b1111, F_EQ, F_EQ});
    vecs.push_back('{"1000/0111", 4'b1000, 4'b0111, F_GT, F_LT});
    vecs.push_back('{"0001/0010", 4'b0001, 4'b0010, F_LT, F_LT});
    vecs.push_back('{"1111/0001", 4'b1111, 4'b0001, F_GT, F_LT});
    vecs.push_back('{"0111/1000", 4'b0111, 4'b1000, F_LT, F_GT});
    vecs.push_back('{"1000/1000", 4'b1000, 4'b1000, F_EQ, F_EQ});
    vecs.push_back('{"1111/0000", 4'b1111, 4'b0000, F_GT, F_LT});
    vecs.push_back('{"0000/0000", 4'b0000, 4'b0000, F_EQ, F_EQ});

    // Reset held: operands toggling with en=1 must not produce a capture.
    #1;
    for (int i = 0; i < 3; i++) begin
      apply(4'(i * 5 + 3), 4'(i * 3));
      step();
      check("rst_hold_u", flags_u(), F_NONE);
      check("rst_hold_s", flags_s(), F_NONE);
    end

    rst_n = 1'b1;
    apply(4'b0000, 4'b0000);
    step();
    check("first_cap_u", flags_u(), F_EQ);
    check("first_cap_s", flags_s(), F_EQ);

    // Back-to-back directed pairs: each result appears one edge after its operands.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      step();
      check({"u ", vecs[i].tag}, flags_u(), vecs[i].exp_u);
      check({"s ", vecs[i].tag}, flags_s(), vecs[i].exp_s);
    end

    // Operand change between edges must not reach the outputs.
    apply(4'b0101, 4'b0011);
    step();
    apply(4'b0001, 4'b0010);
    #3;
    check("no_comb_path_u", flags_u(), F_GT);
    step();
    check("after_change_u", flags_u(), F_LT);

    // Enable hold.
    apply(4'b0101, 4'b0011);
    step();
    check("en_cap_u", flags_u(), F_GT);
    set_en(1'b0);
    apply(4'b0001, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_hold_u", flags_u(), F_GT);
      check("en_hold_s", flags_s(), F_GT);
    end
    set_en(1'b1);
    step();
    check("en_resume_u", flags_u(), F_LT);
    check("en_resume_s", flags_s(), F_LT);

    // Asynchronous reset between edges; the pending capture is discarded.
    apply(4'b0101, 4'b0011);
    step();
    check("pre_arst_u", flags_u(), F_GT);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_now_u", flags_u(), F_NONE);
    check("arst_now_s", flags_s(), F_NONE);
    step();
    check("arst_edge_u", flags_u(), F_NONE);
    rst_n = 1'b1;
    step();
    check("arst_rel_u", flags_u(), F_GT);

    // Exhaustive sweep: operands change every cycle, result one edge later.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply(4'(i), 4'(j));
        step();
        check("sweep_u", flags_u(), ref_flags(4'(i), 4'(j), 1'b0));
        check("sweep_s", flags_s(), ref_flags(4'(i), 4'(j), 1'b1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
